// File: rtl/spy_playback_if.sv
// Bus bundle for spy_playback: the VME pattern-RAM port plus the playback stream.
// Stream handshake: push qualifies data_out for exactly one cycle and is never
// repeated; hold only blocks new reads, so a word read in the cycle before hold
// rises is still pushed one cycle later and the consumer must take it (1-word skid).
interface spy_playback_if #(
    parameter int DATA_W = 21,
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] VMEaddr;
    logic [DATA_W-1:0] vme_wdata;
    logic              vme_we;
    logic [DATA_W-1:0] vme_rdata;
    logic              hold;
    logic [DATA_W-1:0] data_out;
    logic              push;

    modport master (
        output VMEaddr, vme_wdata, vme_we, hold,
        input  vme_rdata, data_out, push
    );

    modport slave (
        input  VMEaddr, vme_wdata, vme_we, hold,
        output vme_rdata, data_out, push
    );
endinterface

// File: rtl/spy_playback.sv
// Pattern playback engine: VME fills a pattern RAM, the engine replays it as pushed words.
// Optional external-trigger arming is enabled with the macro SPY_PLAYBACK_TRIGGER_EN.
module spy_playback #(
    parameter int DATA_W = 21,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    spy_playback_if.slave     bus,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic [ADDR_W-1:0] play_len,
    input  logic              loop_en,
    input  logic              trig,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] play_addr,
    output logic [CNT_W-1:0]  loop_cnt,
    output logic [1:0]        fsm_state
);

`ifdef SPY_PLAYBACK_TRIGGER_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_ARMED = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
    logic unused_trig;
    assign unused_trig = trig;
`endif

    state_t state, state_next;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] len_q;
    logic              loop_q;
    logic              read_issue;
    logic              start_go;
    logic              at_last;

    always_comb begin
        state_next = state;
        read_issue = 1'b0;
        start_go   = 1'b0;
        at_last    = (play_addr == len_q);
        busy       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                // stop wins over a simultaneous start
                if (play_start && !play_stop) begin
                    start_go = 1'b1;
`ifdef SPY_PLAYBACK_TRIGGER_EN
                    state_next = S_ARMED;
`else
                    state_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (play_stop) begin
                    state_next = S_IDLE;
                end else if (!bus.hold) begin
                    read_issue = 1'b1;
                    if (at_last && !loop_q) state_next = S_DONE;
                end
            end
`ifdef SPY_PLAYBACK_TRIGGER_EN
            S_ARMED: begin
                busy = 1'b1;
                if (play_stop) begin
                    state_next = S_IDLE;
                end else if (trig) begin
                    // the trigger cycle already issues the first read
                    state_next = S_RUN;
                    if (!bus.hold) begin
                        read_issue = 1'b1;
                        if (at_last && !loop_q) state_next = S_DONE;
                    end
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            play_addr     <= '0;
            loop_cnt      <= '0;
            done          <= 1'b0;
            len_q         <= '0;
            loop_q        <= 1'b0;
            bus.push      <= 1'b0;
            bus.data_out  <= '0;
            bus.vme_rdata <= '0;
        end else begin
            state         <= state_next;
            bus.push      <= read_issue;
            bus.vme_rdata <= mem[bus.VMEaddr];
            if (read_issue) bus.data_out <= mem[play_addr];

            if (start_go) begin
                play_addr <= '0;
                loop_cnt  <= '0;
                done      <= 1'b0;
                len_q     <= play_len;
                loop_q    <= loop_en;
            end else if (read_issue) begin
                if (!at_last) begin
                    play_addr <= play_addr + 1'b1;
                end else if (loop_q) begin
                    play_addr <= '0;
                    if (loop_cnt != '1) loop_cnt <= loop_cnt + 1'b1;
                end else begin
                    // lands on the same edge as the final push
                    done <= 1'b1;
                end
            end
        end
    end

    // VME writes are locked out while the engine owns the RAM contents
    always_ff @(posedge clk) begin
        if (bus.vme_we && !busy) mem[bus.VMEaddr] <= bus.vme_wdata;
    end

endmodule

// File: tb/tb_spy_playback.sv
// Self-checking bench for spy_playback: scoreboard of expected pushed words plus
// directed checks of VME access, looping, hold skid, stop and (optionally) trigger.
module tb_spy_playback;
    localparam int DATA_W = 21;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              play_start, play_stop, loop_en, trig;
    logic [ADDR_W-1:0] play_len;
    logic              done, busy;
    logic [ADDR_W-1:0] play_addr;
    logic [CNT_W-1:0]  loop_cnt;
    logic [1:0]        fsm_state;

    spy_playback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    spy_playback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .play_start (play_start),
        .play_stop  (play_stop),
        .play_len   (play_len),
        .loop_en    (loop_en),
        .trig       (trig),
        .done       (done),
        .busy       (busy),
        .play_addr  (play_addr),
        .loop_cnt   (loop_cnt),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every pushed word must be the next expected one
    always @(negedge clk) begin
        if (bus.push === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_push", bus.push, 1'b0);
            else                   check("data_out", bus.data_out, exp_q.pop_front());
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic vme_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.VMEaddr   = a;
        bus.vme_wdata = d;
        bus.vme_we    = 1'b1;
        align();
        bus.vme_we    = 1'b0;
    endtask

    task automatic vme_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        bus.VMEaddr = a;
        @(posedge clk);
        @(negedge clk);
        check(tag, bus.vme_rdata, exp);
        align();
    endtask

    task automatic pulse_start();
        play_start = 1'b1;
        align();
        play_start = 1'b0;
    endtask

    task automatic run_until(input string tag, input int n, input int budget, output int first, output int last);
        int c = 0;
        int got = 0;
        first = -1;
        last  = -1;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if (bus.push === 1'b1) begin
                got++;
                if (first < 0) first = c;
                last = c;
            end
        end
        if (got < n) check({tag, "_timeout"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int first, last, cnt;
        logic [3:0] pat;
        reset = 1'b1; play_start = 0; play_stop = 0; loop_en = 0; trig = 1'b1;
        play_len = '0; bus.VMEaddr = '0; bus.vme_wdata = '0; bus.vme_we = 0; bus.hold = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_push", bus.push, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_rdata", bus.vme_rdata, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", play_addr, 0);
        check("rst_loopcnt", loop_cnt, 0);
        align();
        reset = 1'b0;

        // load pattern and read back
        for (int k = 0; k < 8; k++) begin
            model[k] = DATA_W'(k + 'h100);
            vme_write(ADDR_W'(k), model[k]);
        end
        vme_read("rdback5", 10'd5, 21'h105);
        cnt = $urandom_range(0, 7);
        vme_read("rdback_rand", ADDR_W'(cnt), model[cnt]);

        // single pass of 8 words
        play_len = 10'd7; loop_en = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
        pulse_start();
        run_until("pass8", 8, 40, first, last);
        check("first_lat", first, 2);
        check("burst_span", last - first, 7);
        check("done_last", done, 1);
        align();
        @(negedge clk);
        check("busy_after", busy, 0);
        check("done_hold", done, 1);
        check("addr_end", play_addr, 7);
        align();
        check("q_empty1", exp_q.size(), 0);

        // hold for 3 cycles after the 3rd push
        for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
        pulse_start();
        check("done_clr", done, 0);
        run_until("hold_pre", 3, 20, first, last);
        align();
        bus.hold = 1'b1;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[2:0], bus.push};
            if (i == 2) begin
                align();
                bus.hold = 1'b0;
            end
        end
        check("hold_pat", pat, 4'b1000);
        run_until("hold_post", 4, 20, first, last);
        check("hold_resume_lat", first, 1);
        check("done_hold_run", done, 1);
        align();
        check("q_empty2", exp_q.size(), 0);

        // looping pass, then stop
        play_len = 10'd3; loop_en = 1;
        for (int i = 0; i < 24; i++) exp_q.push_back(model[i % 4]);
        pulse_start();
        run_until("loop14", 14, 40, first, last);
        check("loop_cnt", loop_cnt, 3);
        align();
        play_stop = 1'b1;
        @(negedge clk);
        cnt = bus.push;
        align();
        play_stop = 1'b0;
        @(negedge clk);
        check("stop_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            cnt += bus.push;
            @(negedge clk);
        end
        check("stop_extra", (cnt <= 1), 1);
        check("stop_done", done, 0);
        align();
        exp_q.delete();

        // start and stop together from IDLE
        play_start = 1'b1; play_stop = 1'b1;
        align();
        play_start = 1'b0; play_stop = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cnt += bus.push;
        end
        check("ss_push", cnt, 0);
        check("ss_busy", busy, 0);
        align();

        // single-word pass
        play_len = 10'd0; loop_en = 0;
        exp_q.push_back(model[0]);
        pulse_start();
        run_until("len0", 1, 10, first, last);
        check("len0_done", done, 1);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cnt += bus.push;
        end
        check("len0_extra", cnt, 0);
        align();

        // VME write during RUN is ignored
        play_len = 10'd7; loop_en = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
        pulse_start();
        check("busy_run", busy, 1);
        vme_write(10'd2, 21'h1FFFFF);
        run_until("wrrun", 8, 40, first, last);
        align();
        vme_read("wr_blocked", 10'd2, model[2]);

        // reset mid-run
        loop_en = 1;
        for (int i = 0; i < 40; i++) exp_q.push_back(model[i % 8]);
        pulse_start();
        run_until("rstrun", 5, 20, first, last);
        align();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_push", bus.push, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", play_addr, 0);
        check("midrst_loopcnt", loop_cnt, 0);
        align();
        reset = 1'b0;
        exp_q.delete();
        vme_read("ram_kept", 10'd3, model[3]);

`ifdef SPY_PLAYBACK_TRIGGER_EN
        // armed, waiting for trigger
        trig = 1'b0; play_len = 10'd7; loop_en = 0;
        pulse_start();
        cnt = 0; first = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += busy;
            first += bus.push;
        end
        check("armed_busy", cnt, 10);
        check("armed_push", first, 0);
        align();
        for (int i = 0; i < 8; i++) exp_q.push_back(model[i]);
        trig = 1'b1;
        align();
        trig = 1'b0;
        run_until("trig_first", 1, 10, first, last);
        check("trig_lat", first, 1);
        run_until("trig_rest", 7, 20, first, last);
        check("trig_done", done, 1);
        align();

        // stop while armed, VME write blocked while armed
        pulse_start();
        check("armed2_busy", busy, 1);
        vme_write(10'd4, 21'h1ABCD);
        play_stop = 1'b1;
        align();
        play_stop = 1'b0;
        @(negedge clk);
        check("armed_stop_busy", busy, 0);
        check("armed_stop_push", bus.push, 0);
        align();
        vme_read("armed_wr_blocked", 10'd4, model[4]);
`endif

        check("q_empty_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spy_playback.md
Name: spy_playback

Overview:
- Output-direction counterpart of the input spy buffer: VME loads a 1024-word × 21-bit pattern RAM, and the block replays it onto the data stream as words qualified by push.
- Used to inject test patterns into the AMBSLIM datapath in place of live data.
- VME owns RAM port A (write and readback). The playback engine owns port B (read-only).

Parameters:
- DATA_W, 21, stream/RAM word width
- ADDR_W, 10, RAM address width (depth 2**ADDR_W)
- CNT_W, 16, loop counter width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- VMEaddr  input  ADDR_W  VME word address (bits [11:2] of the VME address)
- vme_wdata  input  DATA_W  VME write data
- vme_we  input  1  VME write strobe, one word per cycle
- vme_rdata  output  DATA_W  VME readback of RAM[VMEaddr], 1-cycle latency
- play_start  input  1  start pulse
- play_stop  input  1  abort pulse
- play_len  input  ADDR_W  address of the last word to play
- loop_en  input  1  wrap to address 0 after the last word instead of finishing
- hold  input  1  downstream busy; pauses reads
- trig  input  1  external trigger (used only with the optional feature)
- data_out  output  DATA_W  played word
- push  output  1  data_out valid this cycle
- busy  output  1  engine not IDLE/DONE
- done  output  1  single pass completed
- play_addr  output  ADDR_W  next address to be read
- loop_cnt  output  CNT_W  completed wraps, saturating

Behaviour:
- Reset:
  - State IDLE.
  - play_addr=0, loop_cnt=0, push=0, data_out=0, done=0, busy=0, vme_rdata=0.
  - RAM contents are not cleared.
- Default states (no optional feature): IDLE, RUN, DONE.
- IDLE/DONE + play_start:
  - Go to RUN; latch play_len and loop_en.
  - Clear play_addr, loop_cnt and done.
- RUN, read issue:
  - In each cycle with hold=0, issue a port-B read at play_addr.
  - The next cycle, data_out = RAM[addr] and push=1.
  - Cycles with hold=1 issue no read; push=0 the following cycle, and data_out holds its last value.
  - Downstream must absorb one push in the cycle after it raises hold (1-word skid).
- RUN, address advance after an issued read:
  - If play_addr != latched len: increment play_addr.
  - Else, if loop_en: play_addr=0 and loop_cnt+1, saturating at 2**CNT_W-1.
  - Else: go to DONE. done=1 from the cycle of the final push onward, and stays set until play_start or reset.
- play_len=0: a single word is played per pass.
- play_stop:
  - Stop in RUN (or ARMED) returns the engine to IDLE next cycle; no further reads are issued.
  - A read already issued still produces its push.
  - done stays 0 after a stop.
- Simultaneous events:
  - play_start and play_stop in the same cycle: stop wins.
  - play_start during RUN is ignored.
- VME access:
  - Writes are accepted only while busy=0 and ignored while busy=1.
  - Readback is allowed in every state.
  - A VME write and a playback read to the same address cannot collide, because writes are blocked while busy.
- busy = (state is RUN or ARMED).
- reset mid-RUN: the engine goes to IDLE next edge and push deasserts at that edge.

Optional Feature:
- Macro SPY_PLAYBACK_TRIGGER_EN.
- Defined:
  - play_start goes to ARMED; busy=1, no reads, VME writes blocked.
  - The first cycle with trig=1 in ARMED enters RUN, and the first read issues in that same cycle (subject to hold).
  - play_stop in ARMED returns to IDLE.
- Undefined: there is no ARMED state, trig is ignored, and play_start enters RUN directly.

Test Plan:
- VME write RAM[k]=k+0x100 for k=0..7, then read addr 5 -> vme_rdata=0x105 one cycle later.
- play_len=7, loop_en=0, hold=0, start -> 8 consecutive push cycles starting 1 cycle after entry to RUN with data 0x100..0x107; done=1 with the last push; busy=0 afterwards.
- Same load, hold=1 for 3 cycles after the 3rd push -> exactly one skid push (0x103), then 3 push-free cycles; the sequence resumes at 0x104 with no gaps or duplicates.
- play_len=3, loop_en=1, run 14 reads -> data 0,1,2,3,0,1,... pattern; loop_cnt=3; play_stop -> busy=0 next cycle, at most one further push, done=0.
- During RUN, VME write RAM[2]=0x1FFFFF -> RAM unchanged (readback returns the original value); start+stop same cycle from IDLE -> stays IDLE, no push.
- With SPY_PLAYBACK_TRIGGER_EN: start, trig low 10 cycles -> busy=1, no push; trig pulse -> first push 1 cycle later with RAM[0].
